// File: rtl/ddr_lanectrl_dly_seq_pkg.sv
// ddr_lanectrl_pkg: shared types and defaults for the DQS delay-line sequencer.
//   seq_state_t  - sequencer FSM states
//   DEF_*        - parameter defaults used by the top and the tap tracker
//   clog2_min1   - lane-select width, never less than one bit
package ddr_lanectrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_POST  = 3'd4,
        ST_FIN   = 3'd5
    } seq_state_t;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_TAP_W      = 8;
    localparam int DEF_MAX_TAP    = 255;
    localparam int DEF_PAUSE_PRE  = 2;
    localparam int DEF_PAUSE_POST = 2;
    localparam int DEF_MOVE_GAP   = 1;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ddr_lanectrl_dly_seq_tap_tracker.sv
// ddr_lane_tap_tracker: tracked tap position of one delay line.
//   clk, rst_n      - fabric clock, synchronous active-low reset
//   move, load, dir - the lane's registered MOVE / LOAD / DIRECTION pulses
//   tap             - current tracked tap position
//   would_overflow  - the next move in direction 'dir' would leave 0..MAX_TAP
module ddr_lane_tap_tracker
    import ddr_lanectrl_pkg::*;
#(
    parameter int TAP_W   = DEF_TAP_W,
    parameter int MAX_TAP = DEF_MAX_TAP
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             move,
    input  logic             load,
    input  logic             dir,
    output logic [TAP_W-1:0] tap,
    output logic             would_overflow
);

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAP);

    assign would_overflow = dir ? (tap >= TAP_MAX) : (tap == '0);

    // The sequencer never issues an overflowing pulse; the guard keeps the
    // counter inside range even if it ever did.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap <= '0;
        end else if (load) begin
            tap <= '0;
        end else if (move && !would_overflow) begin
            tap <= dir ? tap + TAP_W'(1) : tap - TAP_W'(1);
        end
    end

endmodule

// File: rtl/ddr_lanectrl_dly_seq.sv
// ddr_lanectrl_dly_seq: multi-lane DQS delay-line sequencer.
// Takes one move/load request at a time, opens a pause window on the target
// lane, issues spaced MOVE pulses (or one LOAD pulse), closes the window and
// reports completion with DONE / DONE_OOR.
//   FAB_CLK, RESET_N            - clock, synchronous active-low reset
//   REQ_*                       - request channel (valid/ready)
//   DONE, DONE_OOR              - completion pulse, abort/illegal qualifier
//   HS_IO_CLK_PAUSE, DELAY_LINE_MOVE/LOAD/DIRECTION - per-lane LANECTRL controls
//   DELAY_LINE_OUT_OF_RANGE     - per-lane range flag from LANECTRL
//   TAP_POS                     - tracked taps, lane 0 in the LSBs
//   state_dbg                   - current FSM state
// Build option: define DDR_LANE_TAP_TRACK_EN to add per-lane tap tracking,
// which also blocks any pulse that would move a tap outside 0..MAX_TAP.
module ddr_lanectrl_dly_seq
    import ddr_lanectrl_pkg::*;
#(
    parameter  int NUM_LANES  = DEF_NUM_LANES,
    parameter  int TAP_W      = DEF_TAP_W,
    parameter  int MAX_TAP    = DEF_MAX_TAP,
    parameter  int PAUSE_PRE  = DEF_PAUSE_PRE,
    parameter  int PAUSE_POST = DEF_PAUSE_POST,
    parameter  int MOVE_GAP   = DEF_MOVE_GAP,
    localparam int LANE_W     = clog2_min1(NUM_LANES)
)(
    input  logic                       FAB_CLK,
    input  logic                       RESET_N,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [LANE_W-1:0]          REQ_LANE,
    input  logic                       REQ_LOAD,
    input  logic                       REQ_DIR,
    input  logic [TAP_W-1:0]           REQ_STEPS,
    output logic                       DONE,
    output logic                       DONE_OOR,
    output logic [NUM_LANES-1:0]       HS_IO_CLK_PAUSE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0] TAP_POS,
    output logic [2:0]                 state_dbg
);

    localparam logic [15:0] PRE_LAST  = 16'(PAUSE_PRE - 1);
    localparam logic [15:0] POST_LAST = 16'(PAUSE_POST - 1);
    localparam logic [15:0] GAP_LAST  = 16'(MOVE_GAP - 1);

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [LANE_W-1:0] l);
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (l == LANE_W'(i)) lane_mask[i] = 1'b1;
        end
    endfunction

    seq_state_t               state;
    logic [LANE_W-1:0]        lane_q;
    logic                     load_q;
    logic [TAP_W-1:0]         steps_q;
    logic                     oor_q;
    logic [15:0]              cnt;
    logic                     ready_q, done_q, done_oor_q;
    logic [NUM_LANES-1:0]     pause_q, move_q, load_p_q, dir_out_q;
    logic [NUM_LANES-1:0]     would_ovf;
    logic [NUM_LANES-1:0]     cur_mask;
    logic                     sel_oor, sel_ovf, req_lane_ok;

    assign cur_mask    = lane_mask(lane_q);
    assign sel_oor     = |(DELAY_LINE_OUT_OF_RANGE & cur_mask);
    // A load always lands on tap 0, so only moves can be blocked by tracking.
    assign sel_ovf     = |(would_ovf & cur_mask) & ~load_q;
    assign req_lane_ok = {1'b0, REQ_LANE} < (LANE_W + 1)'(NUM_LANES);

`ifdef DDR_LANE_TAP_TRACK_EN
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_trk
        ddr_lane_tap_tracker #(
            .TAP_W   (TAP_W),
            .MAX_TAP (MAX_TAP)
        ) u_trk (
            .clk            (FAB_CLK),
            .rst_n          (RESET_N),
            .move           (move_q[i]),
            .load           (load_p_q[i]),
            .dir            (dir_out_q[i]),
            .tap            (TAP_POS[i*TAP_W +: TAP_W]),
            .would_overflow (would_ovf[i])
        );
    end
`else
    // Without tracking MAX_TAP has no effect on the hardware.
    logic unused_max_tap;
    assign unused_max_tap = (MAX_TAP > 0);
    assign TAP_POS        = '0;
    assign would_ovf      = '0;
`endif

    // Handshake: a request transfers on a FAB_CLK edge where REQ_VALID and
    // REQ_READY are both 1. REQ_READY is 1 only in IDLE; it drops on the
    // accept edge and returns the cycle after DONE. REQ_VALID while REQ_READY
    // is 0 is ignored, and the REQ_* fields matter only on the accept edge.
    // All outputs are registered: each transition also sets the outputs of
    // the state being entered.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            lane_q     <= '0;
            load_q     <= 1'b0;
            steps_q    <= '0;
            oor_q      <= 1'b0;
            cnt        <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            done_oor_q <= 1'b0;
            pause_q    <= '0;
            move_q     <= '0;
            load_p_q   <= '0;
            dir_out_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            done_oor_q <= 1'b0;
            move_q     <= '0;
            load_p_q   <= '0;
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        lane_q  <= REQ_LANE;
                        load_q  <= REQ_LOAD;
                        steps_q <= REQ_LOAD ? TAP_W'(1) : REQ_STEPS;
                        oor_q   <= 1'b0;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        if (!req_lane_ok) begin
                            state      <= ST_FIN;
                            done_q     <= 1'b1;
                            done_oor_q <= 1'b1;
                        end else if (!REQ_LOAD && REQ_STEPS == '0) begin
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                        end else begin
                            state     <= ST_PRE;
                            pause_q   <= lane_mask(REQ_LANE);
                            dir_out_q <= (!REQ_LOAD && REQ_DIR) ? lane_mask(REQ_LANE) : '0;
                        end
                    end
                end
                ST_PRE: begin
                    if (cnt == PRE_LAST) begin
                        cnt <= '0;
                        if (sel_ovf) begin
                            state <= ST_POST;
                            oor_q <= 1'b1;
                        end else begin
                            state   <= ST_PULSE;
                            steps_q <= steps_q - TAP_W'(1);
                            if (load_q) load_p_q <= cur_mask;
                            else        move_q   <= cur_mask;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_PULSE: begin
                    cnt <= '0;
                    if (sel_oor) begin
                        state <= ST_POST;
                        oor_q <= 1'b1;
                    end else if (load_q) begin
                        // A load is a single pulse: no trailing gap.
                        state <= ST_POST;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (sel_oor) begin
                        state <= ST_POST;
                        oor_q <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (steps_q == '0) begin
                            state <= ST_POST;
                        end else if (sel_ovf) begin
                            state <= ST_POST;
                            oor_q <= 1'b1;
                        end else begin
                            state   <= ST_PULSE;
                            steps_q <= steps_q - TAP_W'(1);
                            move_q  <= cur_mask;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_POST: begin
                    if (cnt == POST_LAST) begin
                        cnt        <= '0;
                        state      <= ST_FIN;
                        done_q     <= 1'b1;
                        done_oor_q <= oor_q;
                        pause_q    <= '0;
                        dir_out_q  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_FIN: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    pause_q <= '0;
                end
            endcase
        end
    end

    assign REQ_READY            = ready_q;
    assign DONE                 = done_q;
    assign DONE_OOR             = done_oor_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_LOAD      = load_p_q;
    assign DELAY_LINE_DIRECTION = dir_out_q;
    assign state_dbg            = state;

endmodule

// File: tb/tb_ddr_lanectrl_dly_seq.sv
// Directed bench for ddr_lanectrl_dly_seq (default parameters) plus a
// three-lane instance used only for the illegal-lane request.
module tb_ddr_lanectrl_dly_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_load, req_dir;
    logic [1:0]  req_lane;
    logic [7:0]  req_steps;
    logic        req_ready, done, done_oor;
    logic [3:0]  pause, move, load, dir, oor_in;
    logic [31:0] tap_pos;
    logic [2:0]  state_dbg;

    logic        d2_valid, d2_ready, d2_done, d2_done_oor;
    logic [1:0]  d2_lane;
    logic [2:0]  d2_pause, d2_move, d2_load, d2_dir;
    logic [23:0] d2_tap;
    logic [2:0]  d2_state;

    int n_checks = 0;
    int n_fail   = 0;

    // results of the last do_req
    int r_done_cyc, r_moves, r_loads, r_pause, r_first, r_last, r_oor;
    int r_other_bad, r_dir_bad;

    ddr_lanectrl_dly_seq dut (
        .FAB_CLK                 (clk),
        .RESET_N                 (rst_n),
        .REQ_VALID               (req_valid),
        .REQ_READY               (req_ready),
        .REQ_LANE                (req_lane),
        .REQ_LOAD                (req_load),
        .REQ_DIR                 (req_dir),
        .REQ_STEPS               (req_steps),
        .DONE                    (done),
        .DONE_OOR                (done_oor),
        .HS_IO_CLK_PAUSE         (pause),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_LOAD         (load),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_OUT_OF_RANGE (oor_in),
        .TAP_POS                 (tap_pos),
        .state_dbg               (state_dbg)
    );

    ddr_lanectrl_dly_seq #(.NUM_LANES(3)) dut3 (
        .FAB_CLK                 (clk),
        .RESET_N                 (rst_n),
        .REQ_VALID               (d2_valid),
        .REQ_READY               (d2_ready),
        .REQ_LANE                (d2_lane),
        .REQ_LOAD                (1'b0),
        .REQ_DIR                 (1'b1),
        .REQ_STEPS               (8'd3),
        .DONE                    (d2_done),
        .DONE_OOR                (d2_done_oor),
        .HS_IO_CLK_PAUSE         (d2_pause),
        .DELAY_LINE_MOVE         (d2_move),
        .DELAY_LINE_LOAD         (d2_load),
        .DELAY_LINE_DIRECTION    (d2_dir),
        .DELAY_LINE_OUT_OF_RANGE (3'b000),
        .TAP_POS                 (d2_tap),
        .state_dbg               (d2_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request and watches it until DONE (bounded). Cycle 1 is the
    // first cycle after the accept edge. If oor_after > 0, the lane's
    // OUT_OF_RANGE is raised once that many MOVE pulses have been seen.
    task automatic do_req(input int lane, input logic ld, input logic dr,
                          input int steps, input int oor_after);
        logic [3:0] m;
        logic       exp_dir;
        int         cyc;
        m = '0;
        m[lane] = 1'b1;
        exp_dir = ld ? 1'b0 : dr;
        r_done_cyc = -1; r_moves = 0; r_loads = 0; r_pause = 0;
        r_first = -1; r_last = -1; r_oor = -1; r_other_bad = 0; r_dir_bad = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_lane  = 2'(lane);
        req_load  = ld;
        req_dir   = dr;
        req_steps = 8'(steps);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc <= 2000) begin
            if (pause[lane]) r_pause++;
            if (move[lane] || load[lane]) begin
                if (r_first < 0) r_first = cyc;
                r_last = cyc;
            end
            if (move[lane]) r_moves++;
            if (load[lane]) r_loads++;
            if (((pause | move | load | dir) & ~m) != 4'b0) r_other_bad++;
            if (pause[lane] && dir[lane] !== exp_dir) r_dir_bad++;
            if (oor_after > 0 && r_moves == oor_after) oor_in[lane] = 1'b1;
            if (done) begin
                r_done_cyc = cyc;
                r_oor = int'(done_oor);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        oor_in = '0;
    endtask

    initial begin
        int gap_seen;
        int late_done;
        rst_n = 1'b0; req_valid = 1'b0; req_lane = '0; req_load = 1'b0;
        req_dir = 1'b0; req_steps = '0; oor_in = '0;
        d2_valid = 1'b0; d2_lane = '0;

        // 1: reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_done", {done, done_oor}, 0);
        check("rst_pause", pause, 0);
        check("rst_move_load", {move, load}, 0);
        check("rst_dir", dir, 0);
        check("rst_tap", tap_pos, 0);
        check("rst_state", state_dbg, 0);
        rst_n = 1'b1;

        // 2: lane 2 +3
        do_req(2, 1'b0, 1'b1, 3, 0);
        check("mv2_done_cyc", r_done_cyc, 11);
        check("mv2_moves", r_moves, 3);
        check("mv2_pause", r_pause, 10);
        check("mv2_first", r_first, 3);
        check("mv2_last", r_last, 7);
        check("mv2_oor", r_oor, 0);
        check("mv2_other", r_other_bad, 0);
        check("mv2_dir", r_dir_bad, 0);
        check("mv2_fin_ready", req_ready, 0);
        check("mv2_fin_pause", pause, 0);
        @(negedge clk);
        check("mv2_ready_after", req_ready, 1);
`ifdef DDR_LANE_TAP_TRACK_EN
        check("mv2_tap", tap_pos[23:16], 3);
`else
        check("mv2_tap", tap_pos[23:16], 0);
`endif

        // lane 2 -2 (decrement)
        do_req(2, 1'b0, 1'b0, 2, 0);
        check("dn2_done_cyc", r_done_cyc, 9);
        check("dn2_moves", r_moves, 2);
        check("dn2_dir", r_dir_bad, 0);
`ifdef DDR_LANE_TAP_TRACK_EN
        check("dn2_tap", tap_pos[23:16], 1);
`else
        check("dn2_tap", tap_pos[23:16], 0);
`endif

        // 3: lane 1 +5 then load
        do_req(1, 1'b0, 1'b1, 5, 0);
        check("mv1_done_cyc", r_done_cyc, 15);
`ifdef DDR_LANE_TAP_TRACK_EN
        check("mv1_tap", tap_pos[15:8], 5);
`endif
        do_req(1, 1'b1, 1'b1, 7, 0);
        check("ld1_done_cyc", r_done_cyc, 6);
        check("ld1_loads", r_loads, 1);
        check("ld1_moves", r_moves, 0);
        check("ld1_pause", r_pause, 5);
        check("ld1_first", r_first, 3);
        check("ld1_dir", r_dir_bad, 0);
        check("ld1_oor", r_oor, 0);
        check("ld1_tap", tap_pos[15:8], 0);

        // 4: lane 0 +10 with OUT_OF_RANGE after the 4th pulse
        do_req(0, 1'b0, 1'b1, 10, 4);
        check("oor0_moves", r_moves, 4);
        check("oor0_done_cyc", r_done_cyc, 12);
        check("oor0_pause", r_pause, 11);
        check("oor0_oor", r_oor, 1);
        check("oor0_other", r_other_bad, 0);

        // 5: lane 3 to 254, then +3
        do_req(3, 1'b0, 1'b1, 254, 0);
        check("mv3_done_cyc", r_done_cyc, 513);
        do_req(3, 1'b0, 1'b1, 3, 0);
`ifdef DDR_LANE_TAP_TRACK_EN
        check("sat3_moves", r_moves, 1);
        check("sat3_done_cyc", r_done_cyc, 7);
        check("sat3_oor", r_oor, 1);
        check("sat3_tap", tap_pos[31:24], 255);
`else
        check("sat3_moves", r_moves, 3);
        check("sat3_done_cyc", r_done_cyc, 11);
        check("sat3_oor", r_oor, 0);
        check("sat3_tap", tap_pos[31:24], 0);
`endif

        // 6a: zero steps
        do_req(1, 1'b0, 1'b1, 0, 0);
        check("z_done_cyc", r_done_cyc, 1);
        check("z_pause", r_pause, 0);
        check("z_moves", r_moves, 0);
        check("z_oor", r_oor, 0);
        @(negedge clk);
        check("z_ready_after", req_ready, 1);

        // 6b: illegal lane on the three-lane instance
        @(negedge clk);
        d2_valid = 1'b1;
        d2_lane  = 2'd3;
        @(posedge clk);
        @(negedge clk);
        d2_valid = 1'b0;
        check("bad_lane_done", {d2_done, d2_done_oor}, 2'b11);
        check("bad_lane_pause", d2_pause, 0);
        check("bad_lane_ready", d2_ready, 0);
        @(negedge clk);
        check("bad_lane_ready_after", d2_ready, 1);

        // 6c: reset during GAP (lane 2 +3, cycle 4 is the first gap)
        @(negedge clk);
        req_valid = 1'b1; req_lane = 2'd2; req_load = 1'b0;
        req_dir = 1'b1; req_steps = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        gap_seen = 0;
        repeat (3) @(negedge clk);
        if (state_dbg == 3'd3) gap_seen = 1;
        check("rg_in_gap", gap_seen, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rg_pause", pause, 0);
        check("rg_move_dir", {move, load, dir}, 0);
        check("rg_done", {done, done_oor}, 0);
        check("rg_ready", req_ready, 1);
        check("rg_tap", tap_pos, 0);
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || pause != 4'b0) late_done++;
        end
        check("rg_no_done", late_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
